// File: rtl/vec_len_sq_pkg.sv
// vec_len_sq_pkg: fixed-point widths, limits, FSM states and magnitude helper for vec_len_sq
package vec_len_sq_pkg;
   localparam int _WIDTH = 32;
   localparam int BI = 16;
   localparam int FR = _WIDTH - BI;
   localparam int CW = $clog2(_WIDTH);
   typedef logic signed [_WIDTH-1:0] fixed;
   localparam logic [_WIDTH-1:0] FIXED_MAX = {1'b0, {(_WIDTH-1){1'b1}}};
   localparam logic [_WIDTH-2:0] MAG_MAX = '1;
   typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, FIN, DONE} vlsq_state_t;
   // the most-negative value has no positive twin, so clamp its magnitude
   function automatic logic [_WIDTH-2:0] sat_mag(fixed v);
      logic [_WIDTH-1:0] n;
      n = v[_WIDTH-1] ? -v : v;
      return n[_WIDTH-1] ? MAG_MAX : n[_WIDTH-2:0];
   endfunction
endpackage

// File: rtl/vec_len_sq_if.sv
// vec_len_sq_if: operand/result bundle between a requester and vec_len_sq
interface vec_len_sq_if;
   import vec_len_sq_pkg::*;
   logic start;
   fixed x, y, z;
   fixed sq;
   logic ready, overflow, sqrt_start;
   modport master (output start, x, y, z, input sq, ready, overflow, sqrt_start);
   modport slave (input start, x, y, z, output sq, ready, overflow, sqrt_start);
endinterface

// File: rtl/vec_len_sq_mul.sv
// sq_serial_mul: radix-2 serial shift-add squarer, one multiplier bit per cycle LSB first
module sq_serial_mul
   import vec_len_sq_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  i_load,
   input  logic [_WIDTH-2:0]     i_mag,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [2*_WIDTH-1:0]   o_prod
);
   logic [2*_WIDTH-1:0] r_mcand, r_prod;
   logic [_WIDTH-1:0] r_mplier;
   logic [CW-1:0] r_cnt;
   logic r_busy;
   assign o_done = r_busy && r_cnt == CW'(_WIDTH - 1);
   assign o_busy = r_busy;
   assign o_prod = r_prod;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_load) begin
         r_mcand  <= {{(_WIDTH+1){1'b0}}, i_mag};
         r_mplier <= {1'b0, i_mag};
         r_prod   <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         r_busy   <= !o_done;
      end
   end
endmodule

// File: rtl/vec_len_sq.sv
// vec_len_sq: saturated x^2+y^2+z^2 of a fixed vector via one serial squarer,
// with a one-cycle sqrt_start pulse to launch the downstream square root
module vec_len_sq
   import vec_len_sq_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   vec_len_sq_if.slave  bus
);
   vlsq_state_t r_state, w_next;
   logic r_prv_start, r_ready, r_ovf, r_sqrt_start;
   logic [_WIDTH-2:0] r_mag [3];
   logic [1:0] r_k;
   logic [_WIDTH+1:0] r_acc;
   logic [_WIDTH-1:0] r_sq, w_sat;
   logic [2*_WIDTH-1:0] w_prod, w_s;
   logic w_accept, w_busy, w_done, w_s_ovf, w_fin_ovf;
   assign w_accept  = bus.start && !r_prv_start && (r_state == IDLE || r_state == DONE);
   assign w_s       = w_prod >> FR;
   assign w_s_ovf   = w_s > {{_WIDTH{1'b0}}, FIXED_MAX};
   assign w_sat     = w_s_ovf ? FIXED_MAX : w_s[_WIDTH-1:0];
   assign w_fin_ovf = r_acc > {2'b0, FIXED_MAX};
   assign bus.sq         = r_sq;
   assign bus.ready      = r_ready;
   assign bus.overflow   = r_ovf;
   assign bus.sqrt_start = r_sqrt_start;
   sq_serial_mul u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .i_load  (r_state == LOAD),
      .i_mag   (r_mag[r_k]),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_prod  (w_prod)
   );
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: w_next = w_accept ? LOAD : r_state;
         LOAD:       w_next = MUL;
         MUL:        w_next = (w_done || !w_busy) ? ACC : MUL;
         ACC:        w_next = (r_k == 2'd2) ? FIN : LOAD;
         FIN:        w_next = DONE;
         default:    w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_prv_start  <= 1'b0;
         r_k          <= '0;
         r_acc        <= '0;
         r_sq         <= '0;
         r_ready      <= 1'b0;
         r_ovf        <= 1'b0;
         r_sqrt_start <= 1'b0;
      end else begin
         r_prv_start  <= bus.start;
         r_sqrt_start <= r_state == FIN;
         if (w_accept) begin
            r_mag[0] <= sat_mag(bus.x);
            r_mag[1] <= sat_mag(bus.y);
            r_mag[2] <= sat_mag(bus.z);
            r_k      <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_ready  <= 1'b0;
         end
         if (r_state == ACC) begin
            r_acc <= r_acc + {2'b0, w_sat};
            r_k   <= r_k + 1'b1;
            r_ovf <= r_ovf | w_s_ovf;
         end
         if (r_state == FIN) begin
            r_sq    <= w_fin_ovf ? FIXED_MAX : r_acc[_WIDTH-1:0];
            r_ovf   <= r_ovf | w_fin_ovf;
            r_ready <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vec_len_sq.sv
// tb_vec_len_sq: scoreboard bench for vec_len_sq with an arithmetic reference model
module tb_vec_len_sq;
   import vec_len_sq_pkg::*;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   vec_len_sq_if vif();
   vec_len_sq dut (.clock(clock), .reset_n(reset_n), .bus(vif));
   always #5 clock = ~clock;

   typedef struct {logic [31:0] sq; logic ovf; int cyc;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0, pulses = 0;
   logic prev_pulse = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(int x, int y, int z);
      longint v[3];
      longint acc, m, s;
      exp_t e;
      v = '{x, y, z};
      acc = 0;
      e.ovf = 1'b0;
      foreach (v[i]) begin
         m = v[i] < 0 ? -v[i] : v[i];
         if (m > 64'h7FFFFFFF) m = 64'h7FFFFFFF;
         s = (m * m) / 65536;
         if (s > 64'h7FFFFFFF) begin
            s = 64'h7FFFFFFF;
            e.ovf = 1'b1;
         end
         acc += s;
      end
      if (acc > 64'h7FFFFFFF) begin
         acc = 64'h7FFFFFFF;
         e.ovf = 1'b1;
      end
      e.sq = acc[31:0];
      e.cyc = 0;
      return e;
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (vif.sqrt_start) begin
         pulses++;
         check("pulse_width", prev_pulse, 0);
         if (sb.size() == 0) check("unexpected_sqrt_start", sb.size(), 1);
         else begin
            e = sb.pop_front();
            check("sq", $unsigned(vif.sq), e.sq);
            check("overflow", vif.overflow, e.ovf);
            check("ready", vif.ready, 1);
            check("latency", cyc, e.cyc);
         end
      end
      prev_pulse = vif.sqrt_start;
   end

   task automatic start_op(logic [31:0] x, logic [31:0] y, logic [31:0] z, bit exp_on);
      exp_t e;
      @(negedge clock);
      vif.x = x; vif.y = y; vif.z = z; vif.start = 1'b1;
      if (exp_on) begin
         e = model(x, y, z);
         e.cyc = cyc + 104;
         sb.push_back(e);
      end
      @(negedge clock);
      check("ready_drop", vif.ready, 0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         check("timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run(logic [31:0] x, logic [31:0] y, logic [31:0] z);
      start_op(x, y, z, 1'b1);
      wait_done();
      @(negedge clock);
      vif.start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      logic [31:0] r [3];
      vif.start = 1'b0; vif.x = '0; vif.y = '0; vif.z = '0;
      repeat (3) @(negedge clock);
      check("rst_sq", $unsigned(vif.sq), 0);
      check("rst_ready", vif.ready, 0);
      check("rst_overflow", vif.overflow, 0);
      check("rst_sqrt_start", vif.sqrt_start, 0);
      reset_n = 1'b1;
      @(negedge clock);
      run(32'h00030000, 32'h00040000, 32'h0);
      run(32'hFFFE0000, 32'h0, 32'h0);
      run(32'h00008000, 32'h0, 32'h0);
      run(32'h01000000, 32'h0, 32'h0);
      run(32'h00B50000, 32'h00B50000, 32'h00B50000);
      run(32'h00010000, 32'h0, 32'h0);
      run(32'h80000000, 32'h0, 32'h0);
      run(32'h0, 32'h0, 32'h0);
      repeat (16) begin
         foreach (r[i])
            r[i] = ($urandom_range(0, 2) == 0) ? $urandom
                 : 32'($urandom_range(0, 32'h01000000)) - 32'h00800000;
         run(r[0], r[1], r[2]);
      end
      // start held high; a busy-time re-edge must be ignored
      p0 = pulses;
      start_op(32'h00020000, 32'h00010000, 32'h00010000, 1'b1);
      repeat (46) @(negedge clock);
      vif.start = 1'b0;
      vif.x = 32'h00500000;
      @(negedge clock);
      vif.start = 1'b1;
      repeat (250) @(negedge clock);
      check("held_high_pulses", pulses - p0, 1);
      check("held_high_queue", sb.size(), 0);
      sb.delete();
      vif.start = 1'b0;
      @(negedge clock);
      // reset mid-operation discards the result
      start_op(32'h00030000, 32'h0, 32'h0, 1'b0);
      p0 = pulses;
      repeat (38) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check("midrst_ready", vif.ready, 0);
      check("midrst_sq", $unsigned(vif.sq), 0);
      check("midrst_overflow", vif.overflow, 0);
      reset_n = 1'b1;
      vif.start = 1'b0;
      repeat (150) @(negedge clock);
      check("midrst_pulses", pulses - p0, 0);
      run(32'h00010000, 32'h0, 32'h0);
      run(32'h01000000, 32'h0, 32'h0);
      run(32'h00010000, 32'h00010000, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
